// File: rtl/axi_memory_if.sv
// axi_memory_if: write-slave-to-memory bus plus the simple indexed read port.
// The slave modport is the memory side; the master modport is the side that
// drives write traffic and read indices.
interface axi_memory_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RADDR_W = 7
);
  logic               cs;
  logic               writeavail;
  logic [ADDR_W-1:0]  addressout;
  logic [RADDR_W-1:0] readaddy;
  logic [DATA_W-1:0]  Dataout;
  logic [DATA_W-1:0]  readdata;
  logic               finishwrite;
  logic               wr_done;
  logic               addr_err;

  modport slave (
    input  cs, writeavail, addressout, readaddy, Dataout, finishwrite,
    output readdata, wr_done, addr_err
  );

  modport master (
    output cs, writeavail, addressout, readaddy, Dataout, finishwrite,
    input  readdata, wr_done, addr_err
  );
endinterface

// File: rtl/axi_memory.sv
// axi_memory: DEPTH x DATA_W word store behind the AXI write slave.
// Writes commit on the edge they are presented; reads return registered data
// one cycle after the index is presented. All outputs are registered.
// Optional feature macro: MEM_BYPASS_EN -- when defined, a same-index read and
// committed write in one cycle forward the new data to readdata; otherwise the
// read returns the old contents (read-first).
module axi_memory #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 128,
  parameter int RADDR_W = 7
) (
  input  logic           ACLK,
  input  logic           ARESET,
  axi_memory_if.slave    bus
);

  localparam int ADDR_W = 32;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [DATA_W-1:0]  readdata_q, readdata_d;
  logic               wr_done_q, wr_done_d;
  logic               addr_err_q, addr_err_d;

  logic [RADDR_W-1:0] wr_idx;
  logic               wr_in_range;
  logic               wr_req;
  logic               wr_commit;

  // Write decode: only addresses whose upper bits are all zero map onto the array.
  assign wr_idx      = bus.addressout[RADDR_W-1:0];
  assign wr_in_range = (bus.addressout[ADDR_W-1:RADDR_W] == '0);
  assign wr_req      = bus.cs && bus.writeavail;
  assign wr_commit   = wr_req && wr_in_range;

  // Next-state for the array, read register and the two acknowledge pulses.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mem_d      = mem_q;
    readdata_d = readdata_q;
    wr_done_d  = 1'b0;
    addr_err_d = 1'b0;

    if (wr_commit) begin
      mem_d[wr_idx] = bus.Dataout;
    end

    // Read-first: mem_q still holds the pre-write contents during this cycle.
    if (bus.cs) begin
      readdata_d = mem_q[bus.readaddy];
`ifdef MEM_BYPASS_EN
      if (wr_commit && (wr_idx == bus.readaddy)) begin
        readdata_d = bus.Dataout;
      end
`endif
    end

    addr_err_d = wr_req && !wr_in_range;
    wr_done_d  = bus.cs && bus.finishwrite;
  end

  // State register: synchronous reset clears the array and every output.
  always_ff @(posedge ACLK) begin
    // NOTE: non-blocking assignments here so all flops update from the same pre-edge values.
    if (ARESET) begin
      // NOTE: the array is reset because cleared contents after reset are part of the contract;
      // this forces flop-based storage rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      readdata_q <= '0;
      wr_done_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      readdata_q <= readdata_d;
      wr_done_q  <= wr_done_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.wr_done  = wr_done_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_axi_memory.sv
// tb_axi_memory: directed and randomized traffic against axi_memory. The driver
// updates an array-based reference model each cycle and queues the expected
// registered outputs; an independent monitor pops and compares after each edge.
module tb_axi_memory;

  typedef struct {
    logic [31:0] rd;
    logic        done;
    logic        err;
  } exp_t;

  logic ACLK;
  logic ARESET;

  axi_memory_if bus ();

  axi_memory dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  exp_t        exp_q [$];
  logic [31:0] ref_mem [128];
  logic [31:0] ref_rd;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // One bus cycle: drive at the falling edge, advance the model, queue the expected outputs.
  task automatic drive(input logic rst, input logic c, input logic wa,
                       input logic [31:0] addr, input logic [31:0] din,
                       input logic [6:0] ra, input logic fin);
    exp_t        e;
    logic [31:0] old;
    logic        commit;
    @(negedge ACLK);
    ARESET          = rst;
    bus.cs          = c;
    bus.writeavail  = wa;
    bus.addressout  = addr;
    bus.Dataout     = din;
    bus.readaddy    = ra;
    bus.finishwrite = fin;

    if (rst) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      ref_rd = '0;
      e.rd = '0; e.done = 1'b0; e.err = 1'b0;
    end else begin
      old    = ref_mem[ra];
      commit = c && wa && (addr < 32'd128);
      if (commit) ref_mem[addr] = din;
      if (c) begin
        ref_rd = old;
`ifdef MEM_BYPASS_EN
        if (commit && (addr == {25'd0, ra})) ref_rd = din;
`endif
      end
      e.rd   = ref_rd;
      e.done = c && fin;
      e.err  = c && wa && (addr >= 32'd128);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle_read(input logic [6:0] ra);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, ra, 1'b0);
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] din, input logic [6:0] ra);
    drive(1'b0, 1'b1, 1'b1, addr, din, ra, 1'b0);
  endtask

  // Monitor: after every rising edge, compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge ACLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("readdata", bus.readdata, e.rd);
        check("wr_done",  {31'd0, bus.wr_done},  {31'd0, e.done});
        check("addr_err", {31'd0, bus.addr_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    logic [31:0] addr;
    logic [6:0]  ra;
    ARESET          = 1'b1;
    bus.cs          = 1'b0;
    bus.writeavail  = 1'b0;
    bus.addressout  = '0;
    bus.Dataout     = '0;
    bus.readaddy    = '0;
    bus.finishwrite = 1'b0;
    ref_rd          = '0;

    // Reset for two cycles, then read a few indices.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 7'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 7'd0, 1'b0);
    idle_read(7'd0);
    idle_read(7'd2);
    idle_read(7'd127);

    // Sequential writes to one address: last write wins.
    write(32'd2, 32'd1, 7'd0);
    write(32'd2, 32'd2, 7'd0);
    write(32'd2, 32'd3, 7'd0);
    idle_read(7'd2);
    idle_read(7'd3);

    // cs gating: write ignored, readdata holds.
    drive(1'b0, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 7'd5, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 7'd5, 1'b1);
    idle_read(7'd5);

    // Out-of-range write: error pulse, no wrap onto index 0.
    write(32'h80, 32'd7, 7'd0);
    idle_read(7'd0);
    write(32'hFFFF_FF81, 32'd9, 7'd1);
    idle_read(7'd1);

    // Same-index collision.
    write(32'd9, 32'h11, 7'd0);
    write(32'd9, 32'h22, 7'd9);
    idle_read(7'd9);

    // finishwrite pulse, held level, and together with a write.
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 7'd0, 1'b1);
    idle_read(7'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 7'd0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 7'd0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'd20, 32'hA5A5, 7'd20, 1'b1);
    idle_read(7'd20);

    // Mid-burst reset clears everything, including the write it overrides.
    write(32'd30, 32'h1234, 7'd0);
    write(32'd31, 32'h5678, 7'd0);
    drive(1'b1, 1'b1, 1'b1, 32'd32, 32'h9ABC, 7'd30, 1'b1);
    idle_read(7'd30);
    idle_read(7'd31);
    idle_read(7'd32);
    idle_read(7'd9);

    // Randomized traffic concentrated on a few indices to force collisions.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h80;
      else if ($urandom_range(0, 3) == 0) addr = $urandom_range(0, 127);
      else addr = $urandom_range(0, 15);
      ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 85),
            $urandom_range(0, 1) == 1, addr, $urandom, ra, $urandom_range(0, 3) == 0);
    end

    // Bounded drain of outstanding expectations.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge ACLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
